bist_lfsr_tpg: RTL and testbench

BIST_LFSR_TPG -- requirements
Module: bist_lfsr_tpg

---
 rtl/bist_lfsr_tpg.sv | 133 +++++++++++++
 tb/tb_bist_lfsr_tpg.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_lfsr_tpg.sv
// BIST test-pattern generator: 5-bit internal-XOR LFSR (x^5+x^2+1) sequenced
// by a small run controller. It issues a programmable number of patterns, can
// be stalled with hold, and provides enable/clear strobes for a downstream
// signature register (MISR).
module bist_lfsr_tpg #(
  parameter int         CNT_W    = 5,
  parameter logic [4:0] DEF_SEED = 5'b00001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             seed_load,
  input  logic [4:0]       seed,
  input  logic [CNT_W-1:0] num_pat,
  input  logic             hold,
  output logic [4:0]       pattern,
  output logic             pat_valid,
  output logic             misr_enb,
  output logic             misr_clr_n,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Feedback taps of the internal-XOR LFSR: bit 2 receives q[1]^q[4].
  localparam logic [4:0]       TAPS    = 5'b00100;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [4:0]       seed_q;
  logic [4:0]       lfsr_q;
  logic [4:0]       lfsr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             busy_q;
  logic             done_q;
  logic             misr_clr_n_q;
  logic             misr_enb_q;
  logic             last_pat;
  logic [4:0]       seed_safe;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  assign seed_safe = (seed == 5'b00000) ? 5'b00001 : seed;

  // LFSR next state: bit 0 takes the feedback bit, other bits shift up and
  // optionally XOR in the feedback where a tap is present.
  assign lfsr_d[0] = lfsr_q[4];
  generate
    for (genvar gi = 1; gi < 5; gi++) begin : g_lfsr
      assign lfsr_d[gi] = lfsr_q[gi-1] ^ (TAPS[gi] & lfsr_q[4]);
    end
  endgenerate

  // Counter compare wraps mod 2^CNT_W, so a latched count of 0 yields
  // 2^CNT_W patterns with no special case.
  assign cnt_inc  = cnt_q + CNT_ONE;
  assign last_pat = (cnt_inc == num_q);

  // pat_valid must react to hold in the same cycle, so it is decoded here.
  assign pat_valid  = (state_q == S_RUN) && !hold;
  assign pattern    = lfsr_q;
  assign misr_enb   = misr_enb_q;
  assign misr_clr_n = misr_clr_n_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Run controller, LFSR, counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      seed_q       <= DEF_SEED;
      lfsr_q       <= DEF_SEED;
      cnt_q        <= '0;
      num_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misr_clr_n_q <= 1'b1;
      misr_enb_q   <= 1'b0;
    end else begin
      misr_enb_q   <= pat_valid;
      misr_clr_n_q <= 1'b1;
      case (state_q)
        S_IDLE, S_DONE: begin
          // Seed write lands this edge, so a same-cycle start uses it in INIT.
          if (seed_load) begin
            seed_q <= seed_safe;
          end
          if (start) begin
            state_q      <= S_INIT;
            num_q        <= num_pat;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            misr_clr_n_q <= 1'b0;
          end
        end
        S_INIT: begin
          lfsr_q  <= seed_q;
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (!hold) begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_inc;
            if (last_pat) begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // misr_enb is high here for the final pattern issued in RUN.
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_lfsr_tpg.sv
// Self-checking bench for bist_lfsr_tpg. The reference model treats the LFSR
// as multiplication by x in GF(2)[x]/(x^5+x^2+1) and tracks only the seed
// register and the expected pattern stream.
module tb_bist_lfsr_tpg;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       seed_load;
  logic [4:0] seed;
  logic [4:0] num_pat;
  logic       hold;
  logic [4:0] pattern;
  logic       pat_valid;
  logic       misr_enb;
  logic       misr_clr_n;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_seed;
  logic [4:0] pats[$];

  always #5 clk = ~clk;

  bist_lfsr_tpg #(.CNT_W(5), .DEF_SEED(5'b00001)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed_load  (seed_load),
    .seed       (seed),
    .num_pat    (num_pat),
    .hold       (hold),
    .pattern    (pattern),
    .pat_valid  (pat_valid),
    .misr_enb   (misr_enb),
    .misr_clr_n (misr_clr_n),
    .busy       (busy),
    .done       (done)
  );

  // Multiply by x modulo x^5 + x^2 + 1.
  function automatic logic [4:0] lfsr_step(input logic [4:0] v);
    logic [5:0] w;
    w = {v, 1'b0};
    if (w[5]) w = w ^ 6'b100101;
    return w[4:0];
  endfunction

  // One complete run from IDLE/DONE through INIT, RUN, FLUSH into DONE.
  // Valid patterns are collected into pats for scenario-specific checks.
  task automatic run_pattern_sequence(input string name, input bit ld,
                                      input logic [4:0] ld_val, input logic [4:0] np,
                                      input int hold_pct, input int hold_from,
                                      input int hold_len, input bit noise);
    int         n_eff;
    int         k;
    int         cyc;
    int         holds;
    logic [4:0] exp_pat;
    logic       prev_v;
    logic       h;
    n_eff = (np == 5'd0) ? 32 : int'(np);
    pats.delete();
    holds = 0;
    // start cycle (optionally with seed_load)
    @(negedge clk);
    start = 1'b1; seed_load = ld; seed = ld_val; num_pat = np; hold = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s start_busy: busy=%b expected 0", name, busy);
    end
    if (ld) m_seed = (ld_val == 5'd0) ? 5'd1 : ld_val;
    // INIT cycle
    @(negedge clk);
    start = noise ? 1'($urandom_range(1)) : 1'b0;
    seed_load = noise ? 1'($urandom_range(1)) : 1'b0;
    seed = 5'($urandom);
    #1;
    checks++;
    if ({busy, done, misr_clr_n, pat_valid, misr_enb} !== 5'b10000) begin
      errors++;
      $display("FAIL %s init: busy,done,clr_n,valid,enb=%b expected 10000", name,
               {busy, done, misr_clr_n, pat_valid, misr_enb});
    end
    exp_pat = m_seed;
    prev_v  = 1'b0;
    k = 0;
    cyc = 0;
    while (k < n_eff && cyc < 1000) begin
      @(negedge clk);
      h = ((cyc >= hold_from) && (cyc < hold_from + hold_len)) ||
          (int'($urandom_range(99)) < hold_pct);
      hold = h;
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      seed_load = noise ? 1'($urandom_range(1)) : 1'b0;
      seed = 5'($urandom);
      #1;
      checks++;
      if (pattern !== exp_pat) begin
        errors++; $display("FAIL %s pattern[%0d]: got %b expected %b", name, k, pattern, exp_pat);
      end
      checks++;
      if (pat_valid !== !h) begin
        errors++; $display("FAIL %s pat_valid: got %b expected %b (hold=%b)", name, pat_valid, !h, h);
      end
      checks++;
      if (misr_enb !== prev_v) begin
        errors++; $display("FAIL %s misr_enb: got %b expected %b", name, misr_enb, prev_v);
      end
      checks++;
      if ({busy, done, misr_clr_n} !== 3'b101) begin
        errors++; $display("FAIL %s run_status: busy,done,clr_n=%b expected 101", name, {busy, done, misr_clr_n});
      end
      prev_v = !h;
      if (h) begin
        holds++;
      end else begin
        pats.push_back(exp_pat);
        k++;
        exp_pat = lfsr_step(exp_pat);
      end
      cyc++;
    end
    checks++;
    if (k < n_eff) begin
      errors++; $display("FAIL %s timeout: %0d patterns seen, expected %0d", name, k, n_eff);
    end
    // FLUSH cycle
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0; hold = 1'b0;
    #1;
    checks++;
    if ({misr_enb, pat_valid, busy, done, pattern} !== {4'b1010, exp_pat}) begin
      errors++;
      $display("FAIL %s flush: enb,valid,busy,done,pattern=%b expected %b", name,
               {misr_enb, pat_valid, busy, done, pattern}, {4'b1010, exp_pat});
    end
    // DONE cycle
    @(negedge clk);
    #1;
    checks++;
    if ({done, busy, misr_enb, misr_clr_n, pattern} !== {4'b1001, exp_pat}) begin
      errors++;
      $display("FAIL %s done: done,busy,enb,clr_n,pattern=%b expected %b", name,
               {done, busy, misr_enb, misr_clr_n, pattern}, {4'b1001, exp_pat});
    end
    $display("run %s: seed=%b num_pat=%0d patterns=%0d holds=%0d final=%b",
             name, m_seed, np, k, holds, exp_pat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; seed_load = 1'b1; seed = 5'b10101; hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; seed_load = 1'b0;
    #1;
    m_seed = 5'd1;
    checks++;
    if ({pattern, pat_valid, misr_enb, misr_clr_n, busy, done} !== 10'b00001_00100) begin
      errors++;
      $display("FAIL reset_state: pattern,valid,enb,clr_n,busy,done=%b expected 0000100100",
               {pattern, pat_valid, misr_enb, misr_clr_n, busy, done});
    end
    $display("reset: pattern=%b busy=%b done=%b", pattern, busy, done);
  endtask

  task automatic test_basic_8();
    logic [4:0] ref_tab [8];
    ref_tab = '{5'b00001, 5'b00010, 5'b00100, 5'b01000,
                5'b10000, 5'b00101, 5'b01010, 5'b10100};
    run_pattern_sequence("basic8", 1'b0, 5'd0, 5'd8, 0, 0, 0, 1'b0);
    checks++;
    if (pats.size() != 8) begin
      errors++; $display("FAIL basic8 count: got %0d expected 8", pats.size());
    end
    for (int i = 0; i < 8 && i < pats.size(); i++) begin
      checks++;
      if (pats[i] !== ref_tab[i]) begin
        errors++; $display("FAIL basic8 table[%0d]: got %b expected %b", i, pats[i], ref_tab[i]);
      end
    end
  endtask

  task automatic test_seed_zero();
    run_pattern_sequence("seed0", 1'b1, 5'd0, 5'(1 + $urandom_range(9)), 0, 0, 0, 1'b0);
    checks++;
    if (pats.size() == 0 || pats[0] !== 5'b00001) begin
      errors++; $display("FAIL seed0 first: got %b expected 00001", (pats.size() > 0) ? pats[0] : 5'bx);
    end
  endtask

  task automatic test_hold();
    run_pattern_sequence("hold", 1'b1, 5'b01011, 5'd5, 0, 2, 3, 1'b0);
    checks++;
    if (pats.size() != 5) begin
      errors++; $display("FAIL hold count: got %0d expected 5", pats.size());
    end
  endtask

  task automatic test_wrap();
    bit seen [32];
    int dup;
    run_pattern_sequence("wrap", 1'b1, 5'(1 + $urandom_range(30)), 5'd0, 20, 0, 0, 1'b1);
    checks++;
    if (pats.size() != 32 || pats[31] !== pats[0]) begin
      errors++; $display("FAIL wrap last: count %0d, last %b expected %b", pats.size(),
                         (pats.size() == 32) ? pats[31] : 5'bx, pats[0]);
    end
    dup = 0;
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    for (int i = 0; i < 31 && i < pats.size(); i++) begin
      if (pats[i] == 5'd0 || seen[pats[i]]) dup++;
      seen[pats[i]] = 1'b1;
    end
    checks++;
    if (dup != 0) begin
      errors++; $display("FAIL wrap unique: %0d repeated/zero values, expected 0", dup);
    end
  endtask

  task automatic test_back_to_back();
    // Starts straight out of DONE with a same-cycle seed_load; noise while busy.
    run_pattern_sequence("b2b", 1'b1, 5'b10000, 5'(1 + $urandom_range(12)), 25, 0, 0, 1'b1);
    checks++;
    if (pats.size() == 0 || pats[0] !== 5'b10000) begin
      errors++; $display("FAIL b2b first: got %b expected 10000", (pats.size() > 0) ? pats[0] : 5'bx);
    end
  endtask

  task automatic test_reset_in_run();
    run_pattern_sequence("pre_rst", 1'b1, 5'b01011, 5'd3, 0, 0, 0, 1'b0);
    @(negedge clk);
    start = 1'b1; num_pat = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1; hold = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_seed = 5'd1;
    checks++;
    if ({busy, done, pattern, pat_valid, misr_enb, misr_clr_n} !== 10'b00_00001_001) begin
      errors++;
      $display("FAIL rst_run: busy,done,pattern,valid,enb,clr_n=%b expected 0000001001",
               {busy, done, pattern, pat_valid, misr_enb, misr_clr_n});
    end
    hold = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++; $display("FAIL rst_run idle: busy,done=%b expected 00", {busy, done});
      end
    end
    $display("reset during run: busy=%b done=%b pattern=%b", busy, done, pattern);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      run_pattern_sequence("rand", 1'($urandom_range(1)), 5'($urandom),
                           5'($urandom), 30, 0, 0, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed = 5'd0;
    num_pat = 5'd0; hold = 1'b0; m_seed = 5'd1;
    test_reset();
    test_basic_8();
    test_seed_zero();
    test_hold();
    test_wrap();
    test_back_to_back();
    test_reset_in_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
